stream_fifo: RTL and testbench
==============================

# stream_fifo

- Parametrised ready/valid FIFO, successor to the fixed 16-bit, 256-entry sample FIFO.
- Adds configurable width and depth, full back-pressure, first-word-fall-through output, fill level, and almost-full/almost-empty flags.
- Adds an optional drop-on-full streaming mode with sticky overflow/underflow flags in place of self-reset.
- Sits between ADC capture and downstream packetisers/USB endpoints, all in the single system clock domain.

## Interface

Parameters:
- WIDTH, 16, data word width in bits (any value ≥1).
- DEPTH_LOG2, 8, capacity is DEPTH = 2**DEPTH_LOG2 words (2..11).
- DROP_ON_FULL, 0, 0 = back-pressure mode; 1 = streaming mode (in_ready tied 1, writes while full are discarded).
- AF_THRESH, DEPTH-4, almost_full asserted when level ≥ AF_THRESH.
- AE_THRESH, 4, almost_empty asserted when level ≤ AE_THRESH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset. Assertion clears all state immediately. Deassertion is synchronised externally.
- clr  in  1  synchronous flush; highest priority over push/pop.
- in_data  in  WIDTH  write data.
- in_valid  in  1  write request.
- in_ready  out  1  FIFO can accept; push occurs on an edge where in_valid && in_ready.
- out_data  out  WIDTH  head word; stable while out_valid && !out_ready.
- out_valid  out  1  head word present.
- out_ready  in  1  consumer accepts; pop occurs on an edge where out_valid && out_ready.
- level  out  DEPTH_LOG2+1  words accepted and not yet popped (0..DEPTH).
- almost_full  out  1  level ≥ AF_THRESH.
- almost_empty  out  1  level ≤ AE_THRESH.
- overflow  out  1  sticky; a push was attempted while full (DROP_ON_FULL=1 only).
- underflow  out  1  sticky; out_ready was high while out_valid was low and level was 0.

## Operation

- **Storage:** inferred block RAM with registered read, plus one output register providing fall-through. The RAM is only read at addresses written on an earlier edge, so there are no read-during-write hazards.
- **Pointers:** write and read pointers are DEPTH_LOG2+1 bits. Address is the low DEPTH_LOG2 bits; the MSB disambiguates full from empty. Wrap-around is natural binary rollover.
- **Level:** updated every edge as level + push − pop. Total capacity is exactly DEPTH words, counting the output register and any in-flight RAM read.
- **Prefetch:** when the output register is empty, or is being popped this edge, and the RAM holds a word, the RAM read is issued. The output register loads on the following edge.
- **in_ready:**
  - DROP_ON_FULL=0: in_ready = (level != DEPTH). There is no combinational path from out_ready, so a simultaneous pop does not admit a push when full.
  - DROP_ON_FULL=1: in_ready = 1. A push when level == DEPTH is discarded, sets overflow, and leaves the stored contents unchanged, even if a pop occurs the same edge.
- **Simultaneous push and pop:** level is unchanged; both pointers advance.
- **Sticky flags:** overflow and underflow clear only on rst or clr.
- **clr:** on the edge, pointers, level, output register valid and sticky flags go to 0. Any push or pop that edge is ignored.
- **Reset values:** in_ready = 1, out_valid = 0, out_data = 0, level = 0, almost_full = (AF_THRESH == 0), almost_empty = 1, overflow = 0, underflow = 0.

## Timing

- **Write-to-read latency:** a word pushed into an empty FIFO on edge k gives out_valid = 1 after edge k+2, with level = 1 after edge k.
- **Throughput:** one push and one pop per cycle are sustained indefinitely once out_valid is high.
- **Back-to-back pops:** the next word is presented after the same edge that pops the current one. out_valid stays high while level − 1 ≥ 1, except immediately after a push into an empty or nearly empty FIFO (2-cycle fill).
- **Register timing:** level, almost_full, almost_empty, overflow, underflow and out_valid are registered. in_ready is a function of registered level only.
- **Reset mid-operation:** outputs take their reset values asynchronously within the same cycle. No partial pop/push is observable afterwards.

## Test plan

- Reset, then push 0x0001..0x0003 on consecutive cycles with out_ready = 0. Required: out_valid rises 2 cycles after the first push; out_data = 0x0001 held; level = 3; almost_empty = 1.
- DROP_ON_FULL=0, DEPTH_LOG2=4: push 20 words with out_ready = 0. Required: exactly 16 accepted; in_ready = 0 with level = 16; almost_full from level 12. Then pop all: values 0..15 in order, level returns to 0, in_ready = 1.
- DROP_ON_FULL=1, DEPTH_LOG2=4: push 18 words (values 0..17) with out_ready = 0. Required: overflow = 1; pops yield 0..15 only; overflow stays 1 until clr.
- Continuous push/pop for 600 cycles with random out_ready. Required: data order preserved across pointer wrap (>2×DEPTH); level never exceeds DEPTH; no duplicates or losses.
- out_ready = 1 on an empty FIFO. Required: underflow = 1 the next cycle. Then clr: underflow = 0, level = 0, out_valid = 0.
- Assert rst mid-burst at level 7. Required: immediately out_valid = 0, level = 0, in_ready = 1. After release, the first new push appears at the output 2 cycles later, with no stale data.

Source files
------------

// File: rtl/stream_fifo.sv
// ---------------------------------------------------------------------------
// stream_fifo
//
// Parametrised ready/valid FIFO with first-word-fall-through output. Words are
// held in an inferred RAM with a registered read port. A prefetch stage and an
// output register sit after the RAM, so the head word is always presented
// without the consumer having to request it.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   clr          synchronous flush, overrides push and pop
//   in_data      write data
//   in_valid     write request
//   in_ready     FIFO can accept (tied high in drop-on-full mode)
//   out_data     head word, stable while out_valid && !out_ready
//   out_valid    head word present
//   out_ready    consumer accepts the head word
//   level        words accepted and not yet popped (0..DEPTH)
//   almost_full  level >= AF_THRESH
//   almost_empty level <= AE_THRESH
//   overflow     sticky: write attempted while full (drop-on-full mode only)
//   underflow    sticky: out_ready seen while the FIFO was empty
// ---------------------------------------------------------------------------
module stream_fifo #(
    parameter int WIDTH        = 16,
    parameter int DEPTH_LOG2   = 8,
    parameter bit DROP_ON_FULL = 1'b0,
    parameter int AF_THRESH    = (1 << DEPTH_LOG2) - 4,
    parameter int AE_THRESH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    function automatic logic af_flag(input logic [LW-1:0] lvl);
        return int'(lvl) >= AF_THRESH;
    endfunction

    function automatic logic ae_flag(input logic [LW-1:0] lvl);
        return int'(lvl) <= AE_THRESH;
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]    wr_ptr;
    logic [LW-1:0]    rd_ptr;
    logic [WIDTH-1:0] rd_data_p1;
    logic             vld_p1;

    logic             full;
    logic             push;
    logic             pop;
    logic             ram_has_word;
    logic             load_out;
    logic             rd_en;
    logic [LW-1:0]    level_nxt;

    // level counts every stored word (RAM, prefetch stage and output
    // register), so full here means no room anywhere in the pipeline.
    assign full     = (level == FULL_LVL);
    assign in_ready = DROP_ON_FULL || !full;

    // A write while full is refused in back-pressure mode and discarded in
    // drop mode, so push never depends on out_ready.
    assign push = in_valid && !full;
    assign pop  = out_valid && out_ready;

    // The RAM only holds words that have not yet been read out, and the read
    // address is never the address being written this edge.
    assign ram_has_word = (wr_ptr != rd_ptr);

    // The prefetched word moves into the output register when that register
    // is empty or is being emptied. A new RAM read is issued whenever the
    // prefetch slot is free or is being vacated this same edge, which keeps
    // one word queued behind the head for back-to-back pops.
    assign load_out = vld_p1 && (!out_valid || pop);
    assign rd_en    = ram_has_word && (!vld_p1 || load_out);

    always_comb begin
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + 1'b1;
        end else if (!push && pop) begin
            level_nxt = level - 1'b1;
        end
    end

    // ---- stage p0 -> p1: RAM write and registered RAM read ----
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= in_data;
        end
        if (rd_en) begin
            rd_data_p1 <= mem[rd_ptr[DEPTH_LOG2-1:0]];
        end
    end

    // ---- stage p1 -> output register, pointers, level and flags ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            vld_p1       <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            level        <= '0;
            almost_full  <= af_flag('0);
            almost_empty <= ae_flag('0);
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (clr) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            vld_p1       <= 1'b0;
            out_valid    <= 1'b0;
            level        <= '0;
            almost_full  <= af_flag('0);
            almost_empty <= ae_flag('0);
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            vld_p1 <= rd_en || (vld_p1 && !load_out);
            if (load_out) begin
                out_valid <= 1'b1;
                out_data  <= rd_data_p1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
            level        <= level_nxt;
            almost_full  <= af_flag(level_nxt);
            almost_empty <= ae_flag(level_nxt);
            if (DROP_ON_FULL && in_valid && full) begin
                overflow <= 1'b1;
            end
            if (out_ready && !out_valid && (level == '0)) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_fifo.sv
// ---------------------------------------------------------------------------
// tb_stream_fifo
//
// Two 16-deep instances: "a" in back-pressure mode, "b" in drop-on-full mode.
// Stimulus pushes the words each FIFO must deliver into a per-instance queue;
// a monitor per instance pops that queue on every output handshake and also
// tracks the fill level from observed handshakes.
// ---------------------------------------------------------------------------
module tb_stream_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    logic [15:0] a_in_data = '0, b_in_data = '0;
    logic        a_in_valid = 1'b0, b_in_valid = 1'b0;
    logic        a_out_ready = 1'b0, b_out_ready = 1'b0;
    logic        a_in_ready, b_in_ready;
    logic [15:0] a_out_data, b_out_data;
    logic        a_out_valid, b_out_valid;
    logic [4:0]  a_level, b_level;
    logic        a_af, b_af, a_ae, b_ae;
    logic        a_ovf, b_ovf, a_unf, b_unf;

    stream_fifo #(.WIDTH(16), .DEPTH_LOG2(4), .DROP_ON_FULL(1'b0)) dut_a (
        .clk(clk), .rst(rst), .clr(clr),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .level(a_level), .almost_full(a_af), .almost_empty(a_ae),
        .overflow(a_ovf), .underflow(a_unf)
    );

    stream_fifo #(.WIDTH(16), .DEPTH_LOG2(4), .DROP_ON_FULL(1'b1)) dut_b (
        .clk(clk), .rst(rst), .clr(clr),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .level(b_level), .almost_full(b_af), .almost_empty(b_ae),
        .overflow(b_ovf), .underflow(b_unf)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    int lvl_a = 0;
    int lvl_b = 0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Monitor for instance a: level model and output scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            lvl_a = 0;
        end else begin
            chk("a_level_track", a_level, lvl_a);
            chk("a_in_ready_track", a_in_ready, (lvl_a != 16));
            if (clr) begin
                lvl_a = 0;
            end else begin
                if (a_out_valid && a_out_ready) begin
                    if (q_a.size() == 0) begin
                        total_cnt++;
                        $display("FAIL a_pop: got word 0x%0h with nothing expected", a_out_data);
                    end else begin
                        chk("a_pop_data", a_out_data, q_a.pop_front());
                    end
                    lvl_a = lvl_a - 1;
                end
                if (a_in_valid && a_in_ready) lvl_a = lvl_a + 1;
            end
        end
    end

    // Monitor for instance b: writes beyond capacity are dropped.
    always @(negedge clk) begin
        if (!rst) begin
            lvl_b = 0;
        end else begin
            chk("b_level_track", b_level, lvl_b);
            chk("b_in_ready_track", b_in_ready, 1);
            if (clr) begin
                lvl_b = 0;
            end else begin
                automatic int was_full = (lvl_b == 16);
                if (b_out_valid && b_out_ready) begin
                    if (q_b.size() == 0) begin
                        total_cnt++;
                        $display("FAIL b_pop: got word 0x%0h with nothing expected", b_out_data);
                    end else begin
                        chk("b_pop_data", b_out_data, q_b.pop_front());
                    end
                    lvl_b = lvl_b - 1;
                end
                if (b_in_valid && !was_full) lvl_b = lvl_b + 1;
            end
        end
    end

    initial begin
        int seq;

        // Reset values
        #2 rst = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_level", a_level, 0);
        chk("rst_af", a_af, 0);
        chk("rst_ae", a_ae, 1);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_unf", a_unf, 0);
        chk("rst_b_out_valid", b_out_valid, 0);
        chk("rst_b_ovf", b_ovf, 0);
        rst = 1'b1;
        tick();

        // Fall-through latency with three pushes and no consumer
        a_in_valid = 1'b1; a_in_data = 16'h0001; q_a.push_back(16'h0001);
        tick();
        chk("t1_ov_after_k", a_out_valid, 0);
        a_in_data = 16'h0002; q_a.push_back(16'h0002);
        tick();
        chk("t1_ov_after_k1", a_out_valid, 0);
        a_in_data = 16'h0003; q_a.push_back(16'h0003);
        tick();
        chk("t1_ov_after_k2", a_out_valid, 1);
        chk("t1_data_k2", a_out_data, 16'h0001);
        a_in_valid = 1'b0;
        tick();
        chk("t1_level", a_level, 3);
        chk("t1_ae", a_ae, 1);
        chk("t1_data_held", a_out_data, 16'h0001);
        a_out_ready = 1'b1;
        repeat (3) tick();
        a_out_ready = 1'b0;
        chk("t1_level_drained", a_level, 0);
        chk("t1_ov_drained", a_out_valid, 0);

        // Back-pressure: 20 offered, 16 accepted
        for (int i = 0; i < 20; i++) begin
            automatic int l = (i < 16) ? i : 16;
            a_in_valid = 1'b1;
            a_in_data  = 16'(i);
            chk("t2_in_ready", a_in_ready, (i < 16));
            chk("t2_af", a_af, (l >= 12));
            if (i < 16) q_a.push_back(16'(i));
            tick();
        end
        a_in_valid = 1'b0;
        chk("t2_level_full", a_level, 16);
        chk("t2_in_ready_full", a_in_ready, 0);
        chk("t2_af_full", a_af, 1);
        chk("t2_no_ovf", a_ovf, 0);
        a_out_ready = 1'b1;
        repeat (16) tick();
        a_out_ready = 1'b0;
        chk("t2_level_empty", a_level, 0);
        chk("t2_in_ready_empty", a_in_ready, 1);
        chk("t2_ae_empty", a_ae, 1);
        chk("t2_q_empty", q_a.size(), 0);

        // Drop-on-full: 18 offered, 0..15 kept
        for (int i = 0; i < 18; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = 16'(i);
            if (i < 16) q_b.push_back(16'(i));
            tick();
        end
        chk("t3_ovf", b_ovf, 1);
        chk("t3_level_full", b_level, 16);
        // push while full with a simultaneous pop is still discarded
        b_in_data   = 16'h0099;
        b_out_ready = 1'b1;
        tick();
        b_in_valid = 1'b0;
        chk("t3_level_after_pop", b_level, 15);
        repeat (15) tick();
        b_out_ready = 1'b0;
        chk("t3_level_empty", b_level, 0);
        chk("t3_ovf_sticky", b_ovf, 1);
        chk("t3_q_empty", q_b.size(), 0);
        pulse_clr();
        chk("t3_ovf_clr", b_ovf, 0);

        // Underflow and flush
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        chk("t4_unf_set", a_unf, 1);
        tick();
        chk("t4_unf_sticky", a_unf, 1);
        pulse_clr();
        chk("t4_unf_clr", a_unf, 0);
        chk("t4_level_clr", a_level, 0);
        chk("t4_ov_clr", a_out_valid, 0);

        // Continuous traffic with random consumer stalls
        seq = 0;
        a_in_valid = 1'b1;
        for (int c = 0; c < 600; c++) begin
            a_in_data   = 16'(seq);
            a_out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (a_in_ready) begin
                q_a.push_back(16'(seq));
                seq++;
            end
            tick();
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        for (int c = 0; c < 40 && q_a.size() != 0; c++) tick();
        a_out_ready = 1'b0;
        chk("t5_drained", q_a.size(), 0);
        chk("t5_wrapped", (seq > 32), 1);
        pulse_clr();

        // Asynchronous reset mid-burst
        a_in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            a_in_data = 16'(16'h0100 + i);
            q_a.push_back(16'(16'h0100 + i));
            tick();
        end
        a_in_valid = 1'b0;
        chk("t6_level7", a_level, 7);
        #1 rst = 1'b0;
        #1;
        chk("t6_rst_ov", a_out_valid, 0);
        chk("t6_rst_level", a_level, 0);
        chk("t6_rst_in_ready", a_in_ready, 1);
        chk("t6_rst_data", a_out_data, 0);
        q_a.delete();
        tick();
        rst = 1'b1;
        a_in_valid = 1'b1; a_in_data = 16'h0055; q_a.push_back(16'h0055);
        tick();
        a_in_valid = 1'b0;
        tick();
        chk("t6_ov_k1", a_out_valid, 0);
        tick();
        chk("t6_ov_k2", a_out_valid, 1);
        chk("t6_data_k2", a_out_data, 16'h0055);
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        chk("t6_level_end", a_level, 0);
        chk("end_q_a", q_a.size(), 0);
        chk("end_q_b", q_b.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
